// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bomb_pkg
// Purpose  : Shared cell codes, grid size, blast FSM states and cell indexing.
// Revision : 1.0
// ============================================================================
package bomb_pkg;

    localparam int GRID_N  = 10;
    localparam int N_CELLS = GRID_N * GRID_N;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BOMB  = 2'd1;
    localparam logic [1:0] CELL_FLAME = 2'd2;
    localparam logic [1:0] CELL_LAST  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SPREAD = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Only meaningful for x, y < GRID_N; callers guard out-of-range coordinates.
    function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return 7'(x) * 7'(GRID_N) + 7'(y);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_slot.sv
`default_nettype none
// ============================================================================
// Module   : bomb_slot
// Purpose  : One player's bomb: placement accept, fuse countdown, pending flag.
// Revision : 1.0
// ============================================================================
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       req_v_i,
    input  logic [3:0] req_x_i,
    input  logic [3:0] req_y_i,
    input  logic       cell_ok_i,
    input  logic       force_i,
    input  logic       free_i,
    output logic       active_o,
    output logic       pending_o,
    output logic       last_o,
    output logic [3:0] x_o,
    output logic [3:0] y_o
);

    localparam int FW = $clog2(FUSE_TICKS + 1);

    logic          active_q, active_d;
    logic          pending_q, pending_d;
    logic [3:0]    x_q, x_d;
    logic [3:0]    y_q, y_d;
    logic [FW-1:0] fuse_q, fuse_d;
    logic          w_accept;

    assign w_accept = req_v_i && !active_q && cell_ok_i &&
                      (req_x_i < 4'(GRID_N)) && (req_y_i < 4'(GRID_N));

    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        x_d       = x_q;
        y_d       = y_q;
        fuse_d    = fuse_q;
        if (free_i) begin
            active_d  = 1'b0;
            pending_d = 1'b0;
            fuse_d    = '0;
        end else if (w_accept) begin
            active_d  = 1'b1;
            pending_d = 1'b0;
            x_d       = req_x_i;
            y_d       = req_y_i;
            fuse_d    = FW'(FUSE_TICKS);
        end else if (active_q) begin
            if (tick_i && (fuse_q != '0)) begin
                fuse_d = fuse_q - FW'(1);
                if (fuse_q == FW'(1)) begin
                    pending_d = 1'b1;
                end
            end
            // A neighbouring blast can detonate this bomb before its fuse runs out.
            if (force_i) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            fuse_q    <= '0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fuse_q    <= fuse_d;
        end
    end

    assign active_o  = active_q;
    assign pending_o = pending_q;
    assign last_o    = active_q && (pending_q || (fuse_q <= FW'(1)));
    assign x_o       = x_q;
    assign y_o       = y_q;

endmodule
`default_nettype wire

// File: rtl/bomb_manager.sv
`default_nettype none
// ============================================================================
// Module   : bomb_manager
// Purpose  : Two bomb slots, cross-shaped blast spreading, flame/bomb grid,
//            brick-clear pulses and sticky player-hit flags.
// Revision : 1.0
// ============================================================================
module bomb_manager
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS  = 3,
    parameter int RADIUS      = 2,
    parameter int FLAME_TICKS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         bombA_v,
    input  logic [3:0]   bombA_x,
    input  logic [3:0]   bombA_y,
    input  logic         bombB_v,
    input  logic [3:0]   bombB_x,
    input  logic [3:0]   bombB_y,
    input  logic [99:0]  onedim_Arena,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    output logic [99:0]  Bomb_bit0,
    output logic [99:0]  Bomb_bit1,
    output logic [99:0]  arena_clr,
    output logic         hitA,
    output logic         hitB
);

    localparam int TW = $clog2(FLAME_TICKS + 1);

    state_t               state_q;
    logic                 srv_b_q;
    logic [3:0]           cx_q, cy_q, step_q, live_q;
    logic [N_CELLS-1:0]   flame_q, clr_acc_q, arena_clr_q;
    logic [TW-1:0]        ftmr_q;
    logic                 hit_a_q, hit_b_q;

    logic                 w_a_act, w_a_pend, w_a_last, w_b_act, w_b_pend, w_b_last;
    logic [3:0]           w_a_x, w_a_y, w_b_x, w_b_y;
    logic [6:0]           w_a_idx, w_b_idx, w_other_idx;
    logic                 w_other_act;
    logic                 w_a_req_in, w_b_req_in, w_a_cell_ok, w_b_cell_ok, w_a_claim;
    logic [6:0]           w_a_req_idx, w_b_req_idx;
    logic                 w_free_a, w_free_b, w_force_a, w_force_b;

    logic [N_CELLS-1:0]   w_sp_flame, w_sp_brick;
    logic [3:0]           w_kill;
    logic                 w_hit_other, w_off;
    logic signed [5:0]    w_rx, w_ry, w_st;
    logic [6:0]           w_sp_idx;

    logic                 w_pa_in, w_pb_in;
    logic [6:0]           w_pa_idx, w_pb_idx;

    assign w_a_idx = cell_idx(w_a_x, w_a_y);
    assign w_b_idx = cell_idx(w_b_x, w_b_y);

    // Requests: a target is usable only when it shows empty and holds no brick.
    assign w_a_req_in  = (bombA_x < 4'(GRID_N)) && (bombA_y < 4'(GRID_N));
    assign w_b_req_in  = (bombB_x < 4'(GRID_N)) && (bombB_y < 4'(GRID_N));
    assign w_a_req_idx = w_a_req_in ? cell_idx(bombA_x, bombA_y) : 7'd0;
    assign w_b_req_idx = w_b_req_in ? cell_idx(bombB_x, bombB_y) : 7'd0;
    assign w_a_cell_ok = !Bomb_bit0[w_a_req_idx] && !Bomb_bit1[w_a_req_idx] &&
                         !onedim_Arena[w_a_req_idx];
    assign w_a_claim   = bombA_v && !w_a_act && w_a_req_in && w_a_cell_ok;
    assign w_b_cell_ok = !Bomb_bit0[w_b_req_idx] && !Bomb_bit1[w_b_req_idx] &&
                         !onedim_Arena[w_b_req_idx] &&
                         !(w_a_claim && (bombA_x == bombB_x) && (bombA_y == bombB_y));

    assign w_free_a    = (state_q == ST_DONE) && !srv_b_q;
    assign w_free_b    = (state_q == ST_DONE) &&  srv_b_q;
    assign w_force_a   = (state_q == ST_SPREAD) &&  srv_b_q && w_hit_other;
    assign w_force_b   = (state_q == ST_SPREAD) && !srv_b_q && w_hit_other;
    assign w_other_act = srv_b_q ? w_a_act : w_b_act;
    assign w_other_idx = srv_b_q ? w_a_idx : w_b_idx;

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .req_v_i   (bombA_v),
        .req_x_i   (bombA_x),
        .req_y_i   (bombA_y),
        .cell_ok_i (w_a_cell_ok),
        .force_i   (w_force_a),
        .free_i    (w_free_a),
        .active_o  (w_a_act),
        .pending_o (w_a_pend),
        .last_o    (w_a_last),
        .x_o       (w_a_x),
        .y_o       (w_a_y)
    );

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .req_v_i   (bombB_v),
        .req_x_i   (bombB_x),
        .req_y_i   (bombB_y),
        .cell_ok_i (w_b_cell_ok),
        .force_i   (w_force_b),
        .free_i    (w_free_b),
        .active_o  (w_b_act),
        .pending_o (w_b_pend),
        .last_o    (w_b_last),
        .x_o       (w_b_x),
        .y_o       (w_b_y)
    );

    // Arms 0..3 = up, down, left, right; each looks one cell at distance step_q.
    always_comb begin
        w_sp_flame  = '0;
        w_sp_brick  = '0;
        w_kill      = '0;
        w_hit_other = 1'b0;
        w_rx        = '0;
        w_ry        = '0;
        w_off       = 1'b0;
        w_sp_idx    = '0;
        w_st        = {2'b00, step_q};
        for (int d = 0; d < 4; d++) begin
            w_rx = {2'b00, cx_q};
            w_ry = {2'b00, cy_q};
            case (d)
                0:       w_rx = w_rx - w_st;
                1:       w_rx = w_rx + w_st;
                2:       w_ry = w_ry - w_st;
                default: w_ry = w_ry + w_st;
            endcase
            w_off    = (w_rx < 6'sd0) || (w_rx > 6'sd9) || (w_ry < 6'sd0) || (w_ry > 6'sd9);
            w_sp_idx = w_off ? 7'd0 : cell_idx(w_rx[3:0], w_ry[3:0]);
            if (live_q[d]) begin
                if (w_off) begin
                    w_kill[d] = 1'b1;
                end else begin
                    w_sp_flame[w_sp_idx] = 1'b1;
                    if (onedim_Arena[w_sp_idx]) begin
                        w_sp_brick[w_sp_idx] = 1'b1;
                        w_kill[d]            = 1'b1;
                    end
                    if (w_other_act && (w_sp_idx == w_other_idx)) begin
                        w_hit_other = 1'b1;
                    end
                end
            end
        end
    end

    assign w_pa_in  = (playerAx < 4'(GRID_N)) && (playerAy < 4'(GRID_N));
    assign w_pb_in  = (playerBx < 4'(GRID_N)) && (playerBy < 4'(GRID_N));
    assign w_pa_idx = w_pa_in ? cell_idx(playerAx, playerAy) : 7'd0;
    assign w_pb_idx = w_pb_in ? cell_idx(playerBx, playerBy) : 7'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            srv_b_q     <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            step_q      <= '0;
            live_q      <= '0;
            flame_q     <= '0;
            clr_acc_q   <= '0;
            arena_clr_q <= '0;
            ftmr_q      <= '0;
            hit_a_q     <= 1'b0;
            hit_b_q     <= 1'b0;
        end else begin
            arena_clr_q <= '0;
            hit_a_q     <= hit_a_q | (w_pa_in && flame_q[w_pa_idx]);
            hit_b_q     <= hit_b_q | (w_pb_in && flame_q[w_pb_idx]);
            case (state_q)
                ST_IDLE: begin
                    if (w_a_pend) begin
                        srv_b_q <= 1'b0;
                        cx_q    <= w_a_x;
                        cy_q    <= w_a_y;
                        state_q <= ST_ARM;
                    end else if (w_b_pend) begin
                        srv_b_q <= 1'b1;
                        cx_q    <= w_b_x;
                        cy_q    <= w_b_y;
                        state_q <= ST_ARM;
                    end else if (tick && (ftmr_q != '0)) begin
                        ftmr_q <= ftmr_q - TW'(1);
                        if (ftmr_q == TW'(1)) begin
                            flame_q <= '0;
                        end
                    end
                end
                ST_ARM: begin
                    flame_q[cell_idx(cx_q, cy_q)] <= 1'b1;
                    step_q  <= 4'd1;
                    live_q  <= 4'hF;
                    state_q <= ST_SPREAD;
                end
                ST_SPREAD: begin
                    flame_q   <= flame_q | w_sp_flame;
                    clr_acc_q <= clr_acc_q | w_sp_brick;
                    live_q    <= live_q & ~w_kill;
                    step_q    <= step_q + 4'd1;
                    if ((step_q == 4'(RADIUS)) || ((live_q & ~w_kill) == 4'h0)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    arena_clr_q <= clr_acc_q;
                    clr_acc_q   <= '0;
                    ftmr_q      <= TW'(FLAME_TICKS);
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < N_CELLS; c++) begin : g_cell
        logic [1:0] w_code;
        always_comb begin
            if (flame_q[c]) begin
                w_code = CELL_FLAME;
            end else if (w_a_act && (w_a_idx == 7'(c))) begin
                w_code = w_a_last ? CELL_LAST : CELL_BOMB;
            end else if (w_b_act && (w_b_idx == 7'(c))) begin
                w_code = w_b_last ? CELL_LAST : CELL_BOMB;
            end else begin
                w_code = CELL_EMPTY;
            end
        end
        assign Bomb_bit0[c] = w_code[0];
        assign Bomb_bit1[c] = w_code[1];
    end

    assign arena_clr = arena_clr_q;
    assign hitA      = hit_a_q;
    assign hitB      = hit_b_q;

endmodule
`default_nettype wire

// File: tb/tb_bomb_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomb_manager
// Purpose  : Directed vector table plus hand sequences for bomb_manager.
// Revision : 1.0
// ============================================================================
module tb_bomb_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        bombA_v = 1'b0, bombB_v = 1'b0;
    logic [3:0]  bombA_x = '0, bombA_y = '0, bombB_x = '0, bombB_y = '0;
    logic [99:0] onedim_Arena = '0;
    logic [3:0]  playerAx = 4'd9, playerAy = 4'd9, playerBx = 4'd9, playerBy = 4'd8;
    logic [99:0] Bomb_bit0, Bomb_bit1, arena_clr;
    logic        hitA, hitB;

    int n_cmp = 0;
    int n_err = 0;

    bomb_manager dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .bombA_v      (bombA_v),
        .bombA_x      (bombA_x),
        .bombA_y      (bombA_y),
        .bombB_v      (bombB_v),
        .bombB_x      (bombB_x),
        .bombB_y      (bombB_y),
        .onedim_Arena (onedim_Arena),
        .playerAx     (playerAx),
        .playerAy     (playerAy),
        .playerBx     (playerBx),
        .playerBy     (playerBy),
        .Bomb_bit0    (Bomb_bit0),
        .Bomb_bit1    (Bomb_bit1),
        .arena_clr    (arena_clr),
        .hitA         (hitA),
        .hitB         (hitB)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         adv;
        bit         t;
        bit         av;
        logic [3:0] ax;
        logic [3:0] ay;
        int         idx;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [1:0] code(input int i);
        return {Bomb_bit1[i], Bomb_bit0[i]};
    endfunction

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit av, input logic [3:0] ax, input logic [3:0] ay,
                       input bit bv, input logic [3:0] bx, input logic [3:0] by);
        tick = t; bombA_v = av; bombA_x = ax; bombA_y = ay;
        bombB_v = bv; bombB_x = bx; bombB_y = by;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0; bombA_v = 1'b0; bombB_v = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic add(input bit adv, input bit t, input bit av, input logic [3:0] ax,
                       input logic [3:0] ay, input int idx, input logic [1:0] exp);
        vec_t v;
        v.adv = adv; v.t = t; v.av = av; v.ax = ax; v.ay = ay; v.idx = idx; v.exp = exp;
        vecs.push_back(v);
    endtask

    int          cnt;
    int          pulses;
    logic [99:0] cap;
    logic [99:0] one_hot12;

    initial begin
        // Scenario: single bomb at (1,1), empty arena, players far away.
        add(0, 0, 0, 0, 0, 11, 2'd0);
        add(1, 0, 1, 4'd10, 4'd0, 0, 2'd0);
        add(1, 0, 1, 4'd1, 4'd10, 20, 2'd0);
        add(1, 0, 1, 4'd1, 4'd1, 11, 2'd1);
        add(1, 1, 0, 0, 0, 11, 2'd1);
        add(1, 1, 0, 0, 0, 11, 2'd3);
        add(1, 1, 0, 0, 0, 11, 2'd3);
        add(1, 0, 0, 0, 0, 11, 2'd3);
        add(1, 0, 0, 0, 0, 11, 2'd2);
        add(1, 0, 0, 0, 0, 1, 2'd2);
        add(0, 0, 0, 0, 0, 21, 2'd2);
        add(0, 0, 0, 0, 0, 10, 2'd2);
        add(0, 0, 0, 0, 0, 12, 2'd2);
        add(0, 0, 0, 0, 0, 31, 2'd0);
        add(1, 0, 0, 0, 0, 31, 2'd2);
        add(0, 0, 0, 0, 0, 13, 2'd2);
        add(0, 0, 0, 0, 0, 14, 2'd0);
        add(1, 0, 0, 0, 0, 11, 2'd2);
        add(0, 0, 0, 0, 0, 41, 2'd0);
        add(0, 0, 0, 0, 0, 25, 2'd0);
        add(0, 0, 0, 0, 0, 23, 2'd0);
        add(0, 0, 0, 0, 0, 0, 2'd0);
        add(1, 0, 1, 4'd1, 4'd2, 12, 2'd2);
        add(1, 1, 0, 0, 0, 12, 2'd0);
        add(0, 0, 0, 0, 0, 11, 2'd0);
        add(0, 0, 0, 0, 0, 21, 2'd0);

        do_reset();
        chk("reset bit0", Bomb_bit0, '0);
        chk("reset bit1", Bomb_bit1, '0);
        chk("reset arena_clr", arena_clr, '0);
        chk("reset hits", 100'({hitA, hitB}), '0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].adv) cyc(vecs[i].t, vecs[i].av, vecs[i].ax, vecs[i].ay, 0, 0, 0);
            chk($sformatf("vec%0d cell%0d", i, vecs[i].idx), 100'(code(vecs[i].idx)), 100'(vecs[i].exp));
        end
        chk("vec hits", 100'({hitA, hitB}), '0);

        // Brick at (1,2): placement onto it refused, blast stops there and clears it.
        do_reset();
        onedim_Arena = '0;
        onedim_Arena[12] = 1'b1;
        cyc(0, 1, 4'd1, 4'd2, 0, 0, 0);
        chk("brick place refused", 100'(code(12)), 100'(0));
        cyc(0, 1, 4'd1, 4'd1, 0, 0, 0);
        chk("brick scen place", 100'(code(11)), 100'(1));
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        cap = '0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (arena_clr != '0) begin
                pulses++;
                cap = arena_clr;
            end
        end
        one_hot12 = '0;
        one_hot12[12] = 1'b1;
        chk("arena_clr pulses", 100'(pulses), 100'(1));
        chk("arena_clr mask", cap, one_hot12);
        chk("brick cell flamed", 100'(code(12)), 100'(2));
        chk("behind brick", 100'(code(13)), 100'(0));
        chk("down arm", 100'(code(21)), 100'(2));
        onedim_Arena = '0;

        // Chain reaction: A at (1,1) reaches B at (1,3).
        do_reset();
        cyc(0, 1, 4'd1, 4'd1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd1, 4'd3);
        chk("chain B placed", 100'(code(13)), 100'(1));
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("chain B last", 100'(code(13)), 100'(3));
        cnt = 0;
        while (code(13) != 2'd2 && cnt < 10) begin
            idle(1);
            cnt++;
        end
        chk("chain A reaches B", 100'(code(13)), 100'(2));
        chk("chain 15 not yet", 100'(code(15)), 100'(0));
        cnt = 0;
        while (code(15) != 2'd2 && cnt < 10) begin
            idle(1);
            cnt++;
        end
        chk("chain B latency", 100'(cnt), 100'(5));
        chk("chain hits", 100'({hitA, hitB}), '0);

        // Simultaneous same-cell request, then held request.
        do_reset();
        cyc(0, 1, 4'd5, 4'd5, 1, 4'd5, 4'd5);
        chk("same cell A bomb", 100'(code(55)), 100'(1));
        chk("same cell count", 100'($countones(Bomb_bit0 | Bomb_bit1)), 100'(1));
        for (int i = 0; i < 10; i++) cyc(0, 1, 4'd6, 4'd6, 0, 0, 0);
        chk("held A no replace", 100'(code(66)), 100'(0));
        chk("held count", 100'($countones(Bomb_bit0 | Bomb_bit1)), 100'(1));
        cyc(0, 0, 0, 0, 1, 4'd7, 4'd7);
        chk("B was idle", 100'(code(77)), 100'(1));

        // Player hits, then asynchronous reset in the middle of a blast.
        do_reset();
        playerAx = 4'd8; playerAy = 4'd8; playerBx = 4'd2; playerBy = 4'd1;
        cyc(0, 1, 4'd1, 4'd1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        while (!hitB && cnt < 15) begin
            idle(1);
            cnt++;
        end
        chk("hitB set", 100'(hitB), 100'(1));
        chk("hitA clear", 100'(hitA), 100'(0));
        idle(6);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("hitB sticky", 100'(hitB), 100'(1));
        cyc(0, 1, 4'd5, 4'd5, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        chk("mid blast center", 100'(code(55)), 100'(2));
        #2;
        rst = 1'b0;
        #1;
        chk("async rst bit0", Bomb_bit0, '0);
        chk("async rst bit1", Bomb_bit1, '0);
        chk("async rst clr", arena_clr, '0);
        chk("async rst hits", 100'({hitA, hitB}), '0);
        @(negedge clk);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
